// File: rtl/fft_out_reorder.sv
// fft_out_reorder: turns the bit-reversed two-lane output stream of the
// parallel-2 FFT into natural frequency order on the same two-lane format.
// Two flop banks are used ping-pong: one fills while the other is read out.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_up      up-lane sample {re, im}, carries X[bitrev(2c)]
//   in_down    down-lane sample {re, im}, carries X[bitrev(2c+1)]
//   in_valid   input pair accepted on this edge
//   out_up     natural-order sample X[2k]
//   out_down   natural-order sample X[2k+1]
//   out_valid  out_up/out_down hold a valid pair
//   out_last   final pair of a frame
module fft_out_reorder #(
    parameter int unsigned NBITS = 10,
    parameter int unsigned N     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*NBITS-1:0]   in_up,
    input  logic [2*NBITS-1:0]   in_down,
    input  logic                 in_valid,
    output logic [2*NBITS-1:0]   out_up,
    output logic [2*NBITS-1:0]   out_down,
    output logic                 out_valid,
    output logic                 out_last
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned CW   = LOGN - 1;
    localparam int unsigned W    = 2 * NBITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(N / 2 - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // LOGN-bit bit reversal of a frame address
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    logic [W-1:0]  mem [2][N];

    logic [CW-1:0] wcnt;
    logic          wbank;
    logic [1:0]    full;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_next;
    logic          rbank;
    logic          rbank_next;
    logic          rd_en;
    logic [CW-1:0] rd_idx;

    // Frame-complete flag for the bank being written
    always_comb begin
        full_set = 2'b00;
        if (in_valid && (wcnt == CNT_LAST)) begin
            full_set[wbank] = 1'b1;
        end
    end

    // Write position and bank-full flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            // set and clear never hit the same bank on the same edge
            full <= (full & ~full_clr) | full_set;
            if (in_valid) begin
                wcnt <= wcnt + CW'(1);
                if (wcnt == CNT_LAST) begin
                    wbank <= ~wbank;
                end
            end
        end
    end

    // Bank storage, not cleared by reset
    always_ff @(posedge clk) begin
        if (rst && in_valid) begin
            mem[wbank][bitrev({wcnt, 1'b0})] <= in_up;
            mem[wbank][bitrev({wcnt, 1'b1})] <= in_down;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_next = READ;
                end
            end
            READ: begin
                if ((rcnt == CNT_LAST) && !full[~rbank]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read FSM outputs; IDLE issues the first read itself so a bank is
    // emitted the cycle after it fills
    always_comb begin
        rd_en      = 1'b0;
        rd_idx     = rcnt;
        rcnt_next  = rcnt;
        rbank_next = rbank;
        full_clr   = 2'b00;
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    rd_en           = 1'b1;
                    rd_idx          = '0;
                    rcnt_next       = CW'(1);
                    full_clr[rbank] = 1'b1;
                end
            end
            READ: begin
                rd_en     = 1'b1;
                rd_idx    = rcnt;
                rcnt_next = rcnt + CW'(1);
                if (rcnt == CNT_LAST) begin
                    rbank_next = ~rbank;
                    rcnt_next  = '0;
                    if (full[~rbank]) begin
                        full_clr[~rbank] = 1'b1;
                    end
                end
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    // Read position and registered outputs; data holds while not valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_up    <= '0;
            out_down  <= '0;
        end else begin
            rcnt      <= rcnt_next;
            rbank     <= rbank_next;
            out_valid <= rd_en;
            out_last  <= rd_en && (rd_idx == CNT_LAST);
            if (rd_en) begin
                out_up   <= mem[rbank][{rd_idx, 1'b0}];
                out_down <= mem[rbank][{rd_idx, 1'b1}];
            end
        end
    end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder stage placed directly downstream of `topfft`. It consumes the two-lane (up/down) complex output stream of the parallel-2 FFT, which arrives in bit-reversed order. It re-emits each frame in natural frequency order on the same two-lane format. A ping-pong pair of register banks gives continuous streaming with no back-pressure.

## Interface
Parameters:
- `NBITS`, 10, width of one real or imaginary component.
- `N`, 8, FFT size; a power of 2, at least 4. `LOGN = log2(N)` is derived internally.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `in_up`  input  2*NBITS  FFT up-lane sample; packed as `{re[NBITS-1:0], im[NBITS-1:0]}`, real part in the upper half.
- `in_down`  input  2*NBITS  FFT down-lane sample; same packing.
- `in_valid`  input  1  when high, the pair is accepted on this edge.
- `out_up`  output  2*NBITS  natural-order sample X[2k].
- `out_down`  output  2*NBITS  natural-order sample X[2k+1].
- `out_valid`  output  1  `out_up`/`out_down` hold a valid pair.
- `out_last`  output  1  high with the final pair (k = N/2-1) of a frame.

## Operation
- **Input order.** The c-th accepted pair of a frame (c = 0..N/2-1) carries X[bitrev(2c)] on `in_up` and X[bitrev(2c+1)] on `in_down`, using a LOGN-bit reverse. For N=8 the pairs are (0,4), (2,6), (1,5), (3,7).
- **Storage.** There are two banks, each holding N words of 2*NBITS bits, in flops.
- **Write side.**
  - `wcnt` (LOGN-1 bits) and `wbank` (1 bit) track the current write position.
  - On an accepted pair, write bank[`wbank`] at addresses bitrev(2*`wcnt`) and bitrev(2*`wcnt`+1), then increment `wcnt`.
  - When `wcnt` wraps from N/2-1 to 0: toggle `wbank` and set `full[old wbank]`.
- **Read FSM.**
  - IDLE: if any `full` bit is set, move to READ on that bank, clear its `full` bit, set `rcnt` = 0.
  - READ: each cycle, load `out_up` = bank[2*`rcnt`] and `out_down` = bank[2*`rcnt`+1], assert `out_valid`, and increment `rcnt`. `out_last` is asserted when `rcnt` = N/2-1.
  - After the last pair, go straight to READ on the other bank if its `full` bit is set (the load into IDLE is combined with this decision, so there are no bubbles). Otherwise go to IDLE.
  - Banks are read in the order they filled.
- **Gaps.** `in_valid` may drop at any cycle. Gaps only delay `wcnt`; frame contents are unaffected. There is no output stall.
- **No overflow by construction.** Reading a bank takes exactly N/2 cycles, and refilling the other bank takes at least N/2 cycles. No overflow flag is provided.
- **Data handling.** Values are copied bit-exactly; no arithmetic, rounding or sign handling.
- **Reset (`rst` = 0 at an edge).**
  - `wcnt`, `wbank`, `rcnt`, `full` and the FSM go to 0 / IDLE.
  - `out_valid`, `out_last`, `out_up` and `out_down` go to 0.
  - Bank contents are not cleared.
  - Reset wins over a simultaneous `in_valid`. A partial frame, or a frame being read, is discarded.

## Timing
- Let the last pair of a frame be accepted at edge e. The first natural-order pair is registered at edge e+1, and `out_valid` stays high for edges e+1..e+N/2.
- Latency from first input to first output is N/2 cycles for gap-free input. Throughput is 2 samples/cycle.
- Back-to-back frames give continuous `out_valid`. Bank A is refilled no earlier than edge e+N/2+1, after its last read at e+N/2.
- A write and a read never target the same bank in the same cycle. A simultaneous frame-complete and read-complete is handled by the FSM transition above.
- Outputs hold their values while `out_valid` = 0. Only `out_valid`/`out_last` carry meaning.

## Test plan
- **Single frame, N=8.** Encode each sample as re = k, im = 0. Drive pairs (0,4), (2,6), (1,5), (3,7) on 4 consecutive edges. Expect pairs (0,1), (2,3), (4,5), (6,7) starting one cycle after the last input. `out_valid` is high for 4 cycles, `out_last` only on (6,7), and `out_up`/`out_down` carry im = 0.
- **Three back-to-back frames.** Frame f uses re = k + 16f. Expect 12 consecutive `out_valid` cycles with no gaps, natural order, and `out_last` at output cycles 4, 8 and 12.
- **Gapped input.** Alternate `in_valid` 1,0,1,0 over a frame. Expect the same output as the single-frame test, with the first pair one cycle after the 4th accepted pair.
- **Reset mid-write.** Accept 2 pairs, hold `rst` = 0 for one edge, then send a full frame with re = 100+k. Expect only 100..107 on the output, in natural order. All outputs are 0 at the edge after reset.
- **Reset mid-read.** Assert `rst` = 0 during the 2nd output pair. Expect `out_valid`, `out_last`, `out_up` and `out_down` all 0 at that edge. There is no further output until a new full frame arrives.
- **N=16, NBITS=12.** Drive pairs in 4-bit bit-reversed order, (0,8), (4,12), (2,10), …, (7,15). Expect pairs (0,1)..(14,15) over 8 cycles, with `out_last` on (14,15).
